// File: rtl/clk_div_gen.sv
// clk_div_gen: derived clocks from the 100 MHz reference.
// Fixed clk/2 and clk/4 square waves plus a runtime-programmable clk/N
// with a start-of-period tick. A new divisor is held pending and only
// applied on a period boundary, so clk_div_o never glitches.
module clk_div_gen #(
   parameter int CNT_W   = 16,
   parameter int DEF_DIV = 4
) (
   input  logic             clk100,
   input  logic             rst,
   input  logic [CNT_W-1:0] div_val,
   input  logic             div_load,
   output logic             div_ack,
   output logic             div_err,
   output logic             busy,
   output logic             clk50_o,
   output logic             clk25_o,
   output logic             clk_div_o,
   output logic             tick_div
);

   localparam logic [CNT_W-1:0] DEF  = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] ZERO = '0;
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO  = CNT_W'(2);

   logic [1:0]       ph;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cur_div;
   logic [CNT_W-1:0] pend_div;
   logic             at_end;
   logic             load_ok;
   logic             apply;

   // last cycle of the current period; the only place a divisor may change
   assign at_end  = (cnt == cur_div - ONE);
   assign load_ok = div_load && (div_val >= TWO);
   assign apply   = busy && at_end;

   // fixed dividers: clk50 toggles every cycle, clk25 every other cycle
   always_ff @(posedge clk100) begin
      if (!rst) begin
         ph      <= 2'd0;
         clk50_o <= 1'b0;
         clk25_o <= 1'b0;
      end else begin
         ph      <= ph + 2'd1;
         clk50_o <= ~clk50_o;
         if (ph[0]) clk25_o <= ~clk25_o;
      end
   end

   // period counter and registered divided outputs (lag cnt by one cycle)
   always_ff @(posedge clk100) begin
      if (!rst) begin
         cnt       <= ZERO;
         clk_div_o <= 1'b0;
         tick_div  <= 1'b0;
      end else begin
         clk_div_o <= (cnt < (cur_div >> 1));
         tick_div  <= (cnt == ZERO);
         cnt       <= at_end ? ZERO : cnt + ONE;
      end
   end

   // load handshake: latest legal request wins, applied only at period end
   always_ff @(posedge clk100) begin
      if (!rst) begin
         cur_div  <= DEF;
         pend_div <= DEF;
         busy     <= 1'b0;
         div_ack  <= 1'b0;
         div_err  <= 1'b0;
      end else begin
         div_ack <= apply;
         div_err <= div_load && !load_ok;
         if (apply) cur_div <= pend_div;
         // a load coincident with apply queues behind the value being applied
         if (load_ok) begin
            pend_div <= div_val;
            busy     <= 1'b1;
         end else if (apply) begin
            busy     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: every cycle all seven outputs are
// compared against hand-derived expectations.
module tb_clk_div_gen;

   localparam int CNT_W = 16;

   logic             clk100 = 1'b0;
   logic             rst;
   logic [CNT_W-1:0] div_val;
   logic             div_load;
   logic             div_ack, div_err, busy;
   logic             clk50_o, clk25_o, clk_div_o, tick_div;

   int vectors     = 0;
   int miscompares = 0;
   int k           = 0;   // edges since reset release

   always #5 clk100 = ~clk100;

   clk_div_gen #(.CNT_W(CNT_W), .DEF_DIV(4)) dut (
      .clk100   (clk100),
      .rst      (rst),
      .div_val  (div_val),
      .div_load (div_load),
      .div_ack  (div_ack),
      .div_err  (div_err),
      .busy     (busy),
      .clk50_o  (clk50_o),
      .clk25_o  (clk25_o),
      .clk_div_o(clk_div_o),
      .tick_div (tick_div)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // advance one edge out of reset and compare all outputs
   task automatic step(input string tag, input logic ediv, input logic etick,
                       input logic ebusy, input logic eack, input logic eerr);
      @(posedge clk100);
      #1;
      k++;
      chk({tag, ".clk50"}, clk50_o, (k % 2) == 1);
      chk({tag, ".clk25"}, clk25_o, ((k % 4) == 2) || ((k % 4) == 3));
      chk({tag, ".div"},   clk_div_o, ediv);
      chk({tag, ".tick"},  tick_div,  etick);
      chk({tag, ".busy"},  busy,      ebusy);
      chk({tag, ".ack"},   div_ack,   eack);
      chk({tag, ".err"},   div_err,   eerr);
   endtask

   // one edge with rst low: everything must read 0
   task automatic rstep(input string tag);
      @(posedge clk100);
      #1;
      k = 0;
      chk({tag, ".clk50"}, clk50_o,   1'b0);
      chk({tag, ".clk25"}, clk25_o,   1'b0);
      chk({tag, ".div"},   clk_div_o, 1'b0);
      chk({tag, ".tick"},  tick_div,  1'b0);
      chk({tag, ".busy"},  busy,      1'b0);
      chk({tag, ".ack"},   div_ack,   1'b0);
      chk({tag, ".err"},   div_err,   1'b0);
   endtask

   // p quiet periods of divisor n starting at cnt == 0
   task automatic period(input string tag, input int n, input int p);
      for (int j = 0; j < n * p; j++)
         step(tag, (j % n) < (n / 2), (j % n) == 0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst      = 1'b0;
      div_load = 1'b0;
      div_val  = '0;

      // reset state
      rstep("rst0");
      rstep("rst1");
      rst = 1'b1;

      // default divide-by-4 after release: 1,1,0,0 with tick on 1,5,9,13
      period("def4", 4, 4);

      // illegal divisors 0 and 1: err pulses, nothing pending
      div_load = 1'b1; div_val = 16'd0;
      step("ill0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      div_val = 16'd1;
      step("ill1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      div_load = 1'b0;
      step("ill2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("ill3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      period("ill_p4", 4, 2);

      // load 3 at cnt == 1, applied at the wrap
      step("l3a", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      div_load = 1'b1; div_val = 16'd3;
      step("l3b", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      div_load = 1'b0;
      step("l3c", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step("l3ack", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      period("p3", 3, 3);

      // back-to-back 8 then 5 inside one N=3 period: only 5 applies
      div_load = 1'b1; div_val = 16'd8;
      step("b2b8", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      div_val = 16'd5;
      step("b2b5", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      div_load = 1'b0;
      step("b2back", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      period("p5", 5, 2);

      // load 3, then load 6 on the very apply cycle of the pending 3
      div_load = 1'b1; div_val = 16'd3;
      step("co3a", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      div_load = 1'b0;
      step("co3b", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step("co3c", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step("co3d", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      div_load = 1'b1; div_val = 16'd6;
      step("co_ack3", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      div_load = 1'b0;
      step("one3a", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      step("one3b", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step("co_ack6", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      period("p6", 6, 2);

      // reset while 10 is pending: discarded, back to divide-by-4
      div_load = 1'b1; div_val = 16'd10;
      step("r10a", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      div_load = 1'b0;
      step("r10b", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      rstep("mrst0");
      rstep("mrst1");
      rst = 1'b1;
      period("post_p4", 4, 3);

      // smallest legal divisor
      div_load = 1'b1; div_val = 16'd2;
      step("l2a", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      div_load = 1'b0;
      step("l2b", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step("l2c", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step("l2ack", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      period("p2", 2, 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Clock-generation stage built on the 100 MHz reference clock `clk100`.
- Produces registered 50 MHz and 25 MHz square waves (clk/2, clk/4) and one runtime-programmable divided output with a one-cycle tick.
- Feeds downstream blocks and benches that need derived rates, so they no longer run free-standing `always #N` clock generators.
- Divisor changes are glitch-free: they only take effect at a period boundary.

Parameters:
- CNT_W, 16, width of the divisor and the period counter.
- DEF_DIV, 4, divisor loaded at reset (must be >= 2).

Ports:
- clk100  input  1  100 MHz clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset).
- div_val  input  CNT_W  requested divisor N; legal values are N >= 2.
- div_load  input  1  one-cycle request to load div_val.
- div_ack  output  1  one-cycle pulse when the pending divisor becomes active.
- div_err  output  1  one-cycle pulse when div_load carries an illegal div_val (0 or 1).
- busy  output  1  high while a loaded divisor is pending and not yet active.
- clk50_o  output  1  clk100/2, 50 % duty.
- clk25_o  output  1  clk100/4, 50 % duty.
- clk_div_o  output  1  clk100/N.
- tick_div  output  1  one-cycle pulse at the start of each clk_div_o period.

Behaviour:
- Reset (rst == 0 at a rising edge):
  - All outputs go to 0.
  - Internal state: cur_div = DEF_DIV, cnt = 0, pending cleared, 2-bit phase counter ph = 0.
  - Reset asserted mid-operation discards any pending divisor; no div_ack is issued for it.
- Fixed dividers:
  - ph increments each cycle and wraps 3 -> 0.
  - clk50_o toggles every cycle.
  - clk25_o toggles when ph[0] == 1.
  - First cycle after reset release: clk50_o = 1, clk25_o = 0. Second cycle: clk50_o = 0, clk25_o = 1.
- Programmable divider, each non-reset cycle:
  - clk_div_o <= (cnt < (cur_div >> 1)).
  - tick_div <= (cnt == 0).
  - cnt <= (cnt == cur_div-1) ? 0 : cnt+1.
  - Outputs are registered and lag cnt by one cycle.
  - The high time is floor(N/2) cycles and the low time is ceil(N/2) cycles.
  - Example N = 3: 1 cycle high, 2 cycles low.
- Load handshake:
  - div_load = 1 with div_val >= 2: latch into pend_div and set busy = 1 on the next cycle.
  - div_load = 1 with div_val < 2: pulse div_err on the next cycle; pend_div and busy are unchanged.
  - div_load while busy: the newer legal value overwrites pend_div (latest wins); only one div_ack is issued.
- Apply point:
  - When busy and cnt == cur_div-1, the next edge sets cur_div <= pend_div, cnt <= 0, busy <= 0, and div_ack <= 1 for one cycle.
  - If div_load arrives in the same cycle as the apply point, the old pend_div is applied. The new value is latched as the next pending and busy stays 1.
- No change is ever applied mid-period.
- Counter and cur_div are unsigned CNT_W bits; the maximum divisor is 2^CNT_W - 1.
- div_ack and div_err are never high in the same cycle for the same request.

Test Plan:
- Reset release, DEF_DIV = 4, run 16 cycles:
  - clk50_o = 1,0,1,0…
  - clk25_o = 0,1,1,0,0,1,1,0…
  - clk_div_o = 1,1,0,0 repeating.
  - tick_div high on cycles 1, 5, 9, 13.
- Load div_val = 3 mid-period (cnt = 1):
  - busy = 1 until the wrap.
  - div_ack pulses exactly once at the period boundary.
  - Then clk_div_o = 1,0,0 repeating, and tick_div every 3 cycles.
- div_val = 0, then div_val = 1, each with div_load:
  - div_err pulses each time.
  - busy stays 0 and the period is unchanged at 4.
- Back-to-back loads of 8 then 5 within one period: a single div_ack, then period 5 (2 cycles high, 3 low); 8 never appears.
- div_load with 6 coincident with the apply cycle of a pending 3:
  - Exactly one N = 3 period runs.
  - A second div_ack follows.
  - Then period 6 (3 high, 3 low).
- Assert rst while busy with pend_div = 10:
  - All outputs are 0 during reset.
  - After release the period is 4 with no div_ack.
  - A subsequent load of 2 yields clk_div_o = 1,0 alternating.
